// File: rtl/fc_pkg.sv
// Shared types for the FC1 -> FC2 activation / ping-pong buffer stage.
//   q4_12_t    : signed Q4.12 element
//   w_state_t  : write (capture + activate) FSM states
//   r_state_t  : read (dispatch to FC2) FSM states
//   LANE_CNT_W : width of the activation chunk counter (up to 255 chunks)
package fc_pkg;
    localparam int Q_WIDTH    = 16;
    localparam int LANE_CNT_W = 8;

    typedef logic signed [Q_WIDTH-1:0] q4_12_t;

    typedef enum logic {
        W_IDLE,
        W_ACT
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_BUSY
    } r_state_t;
endpackage

// File: rtl/fc_relu_lane.sv
// One combinational activation lane: ReLU with optional upper clamp (ReLU-N).
//   x : signed input element
//   y : activated element, same width, no rounding
module fc_relu_lane #(
    parameter int                           DATA_WIDTH = 16,
    parameter bit                           CLAMP_EN   = 1'b0,
    parameter logic signed [DATA_WIDTH-1:0] CLAMP_MAX  = 16'sh6000
) (
    input  logic signed [DATA_WIDTH-1:0] x,
    output logic signed [DATA_WIDTH-1:0] y
);
    always_comb begin
        y = x;
        if (x[DATA_WIDTH-1]) begin
            y = '0;
        end else if (CLAMP_EN && (x > CLAMP_MAX)) begin
            y = CLAMP_MAX;
        end
    end
endmodule

// File: rtl/fc_act_pingpong.sv
// Activation and double-buffer stage between FC1 and FC2.
// A full FC1 vector is captured raw into the free bank, activated in place
// K lanes per cycle, then handed to FC2 with a one-cycle start pulse. The
// bank stays stable until FC2 reports done; the other bank can fill meanwhile.
//
// Handshake: FC1 may pulse in_valid at any time; the vector is taken only when
// in_ready is high in that cycle, otherwise it is discarded and drop_err sticks.
// FC2 sees out_start for one cycle and owns the bank until it pulses down_done.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   in_valid      : FC1 done pulse, in_vector valid in the same cycle
//   in_vector     : raw FC1 vector, element 0 first
//   in_ready      : a free bank exists and the write FSM is idle
//   out_vector    : activated vector of bank rd_sel
//   out_start     : FC2 start pulse
//   down_done     : FC2 done pulse
//   busy          : FC2 owns a bank
//   drop_err      : sticky, a vector arrived while in_ready was low
//   wr_state      : write FSM state (debug)
//   rd_state      : read FSM state (debug)
module fc_act_pingpong
    import fc_pkg::*;
#(
    parameter int                           DATA_WIDTH = 16,
    parameter int                           VEC_DIM    = 200,
    parameter int                           K          = 4,
    parameter bit                           CLAMP_EN   = 1'b0,
    parameter logic signed [DATA_WIDTH-1:0] CLAMP_MAX  = 16'sh6000
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    input  logic [0:VEC_DIM-1][DATA_WIDTH-1:0]  in_vector,
    output logic                                in_ready,
    output logic [0:VEC_DIM-1][DATA_WIDTH-1:0]  out_vector,
    output logic                                out_start,
    input  logic                                down_done,
    output logic                                busy,
    output logic                                drop_err,
    output w_state_t                            wr_state,
    output r_state_t                            rd_state
);
    localparam int P = (VEC_DIM + K - 1) / K;
    localparam logic [LANE_CNT_W-1:0] P_LAST = LANE_CNT_W'(P - 1);

    logic [DATA_WIDTH-1:0]  bank [2][VEC_DIM];
    logic [1:0]             full;
    logic                   wr_sel;
    logic                   rd_sel;
    logic [LANE_CNT_W-1:0]  cnt;
    logic [DATA_WIDTH-1:0]  lane_y [K];

    logic owned_wr;
    logic full_set;
    logic full_clr;

    // A bank is owned by FC2 from R_START until down_done; busy tracks exactly that.
    assign owned_wr = busy && (rd_sel == wr_sel);
    assign in_ready = (wr_state == W_IDLE) && !full[wr_sel] && !owned_wr;
    assign full_set = (wr_state == W_ACT) && (cnt == P_LAST);
    assign full_clr = (rd_state == R_BUSY) && down_done;

    // K activation lanes; lane l handles element cnt*K+l. Lanes past the end
    // of the vector see zero and their results are never written back.
    for (genvar l = 0; l < K; l++) begin : g_lane
        logic [DATA_WIDTH-1:0] x;
        always_comb begin
            x = '0;
            for (int c = 0; c < P; c++) begin
                if ((c * K + l < VEC_DIM) && (cnt == LANE_CNT_W'(c))) begin
                    x = bank[wr_sel][c * K + l];
                end
            end
        end
        fc_relu_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .CLAMP_EN   (CLAMP_EN),
            .CLAMP_MAX  (CLAMP_MAX)
        ) u_lane (
            .x (x),
            .y (lane_y[l])
        );
    end

    // Write FSM: capture raw vector, then activate one chunk per cycle in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= W_IDLE;
            wr_sel   <= 1'b0;
            cnt      <= '0;
            drop_err <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < VEC_DIM; e++) begin
                    bank[b][e] <= '0;
                end
            end
        end else begin
            if (in_valid && !in_ready) begin
                drop_err <= 1'b1;
            end
            case (wr_state)
                W_IDLE: begin
                    if (in_valid && in_ready) begin
                        for (int e = 0; e < VEC_DIM; e++) begin
                            bank[wr_sel][e] <= in_vector[e];
                        end
                        cnt      <= '0;
                        wr_state <= W_ACT;
                    end
                end
                W_ACT: begin
                    for (int e = 0; e < VEC_DIM; e++) begin
                        if (cnt == LANE_CNT_W'(e / K)) begin
                            bank[wr_sel][e] <= lane_y[e % K];
                        end
                    end
                    if (cnt == P_LAST) begin
                        wr_sel   <= ~wr_sel;
                        wr_state <= W_IDLE;
                    end else begin
                        cnt <= cnt + LANE_CNT_W'(1);
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Full flags: the writer never targets a full bank, so a set and a clear
    // on the same edge always hit different banks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 2'b00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (full_set && (wr_sel == b[0])) begin
                    full[b] <= 1'b1;
                end else if (full_clr && (rd_sel == b[0])) begin
                    full[b] <= 1'b0;
                end
            end
        end
    end

    // Read FSM: dispatch banks in capture order with registered start/busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state  <= R_IDLE;
            rd_sel    <= 1'b0;
            out_start <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    out_start <= 1'b0;
                    if (full[rd_sel]) begin
                        rd_state  <= R_START;
                        out_start <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                R_START: begin
                    out_start <= 1'b0;
                    rd_state  <= R_BUSY;
                end
                R_BUSY: begin
                    if (down_done) begin
                        rd_sel   <= ~rd_sel;
                        busy     <= 1'b0;
                        rd_state <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        out_vector = '0;
        for (int e = 0; e < VEC_DIM; e++) begin
            out_vector[e] = bank[rd_sel][e];
        end
    end
endmodule

// File: doc/fc_act_pingpong.md
Name: fc_act_pingpong

Overview:
- Activation and buffer stage between the FC1 layer and the FC2 layer of the BiLSTM localization head.
- Captures FC1's full output vector on its done pulse.
- Applies ReLU, with an optional upper clamp, K lanes per cycle into one of two banks.
- Hands a stable, activated vector to FC2 with a start pulse, holding it until FC2 reports done. The second bank lets the next FC1 result land while FC2 is still computing.

Parameters:
- DATA_WIDTH, 16, element width, signed Q4.12.
- VEC_DIM, 200, vector length; equals FC1 OUT_DIM and FC2 IN_DIM.
- K, 4, activation lanes per cycle; VEC_DIM need not be a multiple of K.
- CLAMP_EN, 0, 1 = saturate activated values at CLAMP_MAX (ReLU-N).
- CLAMP_MAX, 16'sh6000, clamp ceiling (6.0 in Q4.12), used only when CLAMP_EN=1.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, one-cycle pulse (FC1 out_done); in_vector valid in that cycle.
- in_vector, input, DATA_WIDTH x [0:VEC_DIM-1], signed FC1 result.
- in_ready, output, 1, a free bank exists and the write FSM is idle.
- out_vector, output, DATA_WIDTH x [0:VEC_DIM-1], activated vector from the selected read bank.
- out_start, output, 1, one-cycle pulse to FC2 start.
- down_done, input, 1, FC2 out_done pulse.
- busy, output, 1, FC2 owns a bank (R_START or R_BUSY).
- drop_err, output, 1, sticky: in_valid arrived while in_ready=0.

Behaviour:
- Reset (asynchronous, immediate):
  - Both banks zero; full/owned flags clear; wr_sel=0; rd_sel=0.
  - Write FSM to W_IDLE, read FSM to R_IDLE.
  - Outputs: out_start=0, busy=0, drop_err=0, in_ready=1, out_vector=0.
- Reset mid-operation discards all data; no out_start follows.
- Write FSM:
  - W_IDLE: in_ready = (bank wr_sel not full and not owned). On in_valid && in_ready, copy in_vector raw into bank wr_sel, clear lane counter, go to W_ACT.
  - W_ACT: each cycle, activate elements [cnt*K .. cnt*K+K-1] in place; lanes beyond VEC_DIM-1 are masked.
  - After P = ceil(VEC_DIM/K) cycles: set full[wr_sel], toggle wr_sel, return to W_IDLE.
  - in_ready=0 throughout W_ACT.
  - in_valid with in_ready=0 is ignored and sets drop_err, which clears only on reset.
- Activation, per element x:
  - y = 0 if x < 0.
  - else y = CLAMP_MAX if CLAMP_EN and x > CLAMP_MAX.
  - else y = x.
  - Pure function, no rounding; the width is unchanged.
- Read FSM:
  - R_IDLE: if full[rd_sel], go to R_START.
  - R_START: out_start=1 for exactly one cycle, busy=1, go to R_BUSY.
  - R_BUSY: busy=1. On down_done: clear full[rd_sel], toggle rd_sel, go to R_IDLE.
  - down_done in R_IDLE or R_START is ignored.
- out_vector is driven from bank rd_sel at all times. It is stable from R_START through the down_done cycle, because the write FSM can never target a full bank.
- Banks are dispatched strictly in capture order, alternating 0, 1, 0, ...
- Latency: with in_valid sampled at edge E, full is set at edge E+P, R_START is entered at edge E+P+1, and out_start is high in the cycle after edge E+P+1.
- Simultaneous events:
  - down_done freeing bank b in the same cycle that the write FSM checks bank b: the free is seen next cycle, so in_ready rises one cycle later.
  - Processing completes on the same edge as down_done: both flag updates apply; the read FSM then dispatches from R_IDLE.
- Both banks full: in_ready=0 until FC2 finishes the older bank.

Decomposition:
- Shared package fc_pkg:
  - Q4.12 element typedef.
  - Write state enum {W_IDLE, W_ACT} and read state enum {R_IDLE, R_START, R_BUSY}.
  - Constant for the lane-count width.
- One sub-module, fc_relu_lane: combinational per-element ReLU/clamp parameterised by DATA_WIDTH, CLAMP_EN and CLAMP_MAX. Instantiated K times in a generate loop.

Test Plan:
- VEC_DIM=8, K=4; in_valid with {-1, 0, 0x1000, -0x8000, 0x7FFF, 5, -5, 0x2000} -> out_start high exactly in cycle E+4, out_vector={0, 0, 0x1000, 0, 0x7FFF, 5, 0, 0x2000}, busy=1 until down_done.
- Same vector with CLAMP_EN=1, CLAMP_MAX=0x6000 -> element 4 = 0x6000, all others as above.
- VEC_DIM=10, K=4 -> P=3; elements 8-9 activated, no out-of-range write, out_start at E+5.
- Two back-to-back in_valid pulses P+1 cycles apart with FC2 held busy -> second capture lands in bank 1. in_ready=0 after it. A third in_valid sets drop_err=1. After down_done, bank 1 is dispatched with out_start one cycle after R_IDLE is re-entered.
- down_done pulsed while in R_IDLE -> no state change, full flags unchanged.
- Assert rst in mid-W_ACT and again in R_BUSY -> all outputs return to reset values immediately; no out_start for 20 cycles with no in_valid.
